// File: rtl/gpu_pkg.sv
// Shared GPU definitions: OBM byte layout, screen geometry, object slot record
// and the line-evaluator state encoding.
package gpu_pkg;

  localparam logic [1:0] OBM_XP_OFS    = 2'd0;
  localparam logic [1:0] OBM_YP_OFS    = 2'd1;
  localparam logic [1:0] OBM_ATTR_OFS  = 2'd2;
  localparam logic [1:0] OBM_COLOR_OFS = 2'd3;

  localparam int SCREEN_VISIBLE_LINES = 240;
  localparam int OBJECT_SIZE          = 8;

  typedef struct packed {
    logic [5:0] obma;
    logic [2:0] row;
  } obj_slot_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } eval_state_t;

  // 9-bit compare so an object near the bottom never wraps onto line 0.
  function automatic logic obj_y_hit(input logic [7:0] target_y, input logic [7:0] obj_y);
    logic [8:0] t9;
    logic [8:0] y9;
    t9 = {1'b0, target_y};
    y9 = {1'b0, obj_y};
    return (t9 >= y9) && (t9 < (y9 + 9'(OBJECT_SIZE)));
  endfunction

endpackage

// File: rtl/object_line_evaluator_m_if.sv
// OBM read port between the line evaluator (master) and object memory (slave).
interface object_line_evaluator_m_if;
  logic [7:0] obm_addr;
  logic [7:0] obm_data;

  modport master (output obm_addr, input obm_data);
  modport slave  (input obm_addr, output obm_data);
endinterface

// File: rtl/object_line_evaluator_m_slot_table.sv
// Double-buffered object slot table: the back bank fills during the scan, the
// active bank is only ever replaced wholesale on commit.
module object_slot_table_m
  import gpu_pkg::*;
#(
  parameter int MAX_SLOTS = 8,
  parameter int HC_W      = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   hit,
  input  obj_slot_t              hit_slot,
  input  logic                   commit,
  output logic [MAX_SLOTS-1:0]   slot_valid,
  output logic [6*MAX_SLOTS-1:0] slot_obma,
  output logic [3*MAX_SLOTS-1:0] slot_row,
  output logic [HC_W-1:0]        hit_count,
  output logic                   overflow
);

  localparam int FILL_W = $clog2(MAX_SLOTS + 1);
  localparam int SLOT_W = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;

  obj_slot_t              back_q [MAX_SLOTS];
  logic [MAX_SLOTS-1:0]   back_valid_q;
  logic [FILL_W-1:0]      fill_q;
  logic [HC_W-1:0]        back_hits_q;
  logic                   back_ovf_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 0; k < MAX_SLOTS; k++) back_q[k] <= '0;
      back_valid_q <= '0;
      fill_q       <= '0;
      back_hits_q  <= '0;
      back_ovf_q   <= 1'b0;
    end else if (hit) begin
      back_hits_q <= back_hits_q + HC_W'(1);
      if (fill_q < FILL_W'(MAX_SLOTS)) begin
        back_q[fill_q[SLOT_W-1:0]]       <= hit_slot;
        back_valid_q[fill_q[SLOT_W-1:0]] <= 1'b1;
        fill_q                           <= fill_q + FILL_W'(1);
      end else begin
        back_ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      slot_obma  <= '0;
      slot_row   <= '0;
      hit_count  <= '0;
      overflow   <= 1'b0;
    end else if (commit) begin
      slot_valid <= back_valid_q;
      for (int k = 0; k < MAX_SLOTS; k++) begin
        slot_obma[6*k +: 6] <= back_q[k].obma;
        slot_row[3*k +: 3]  <= back_q[k].row;
      end
      hit_count <= back_hits_q;
      overflow  <= back_ovf_q;
    end
  end

endmodule

// File: rtl/object_line_evaluator_m.sv
// Per-line object evaluator: scans OBM Y bytes during hblank and publishes the
// first MAX_SLOTS objects hitting the next line. Option: OBJECT_YHIDE_EN.
module object_line_evaluator_m
  import gpu_pkg::*;
#(
  parameter int NUM_OBJECTS = 64,
  parameter int MAX_SLOTS   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          yp,
  input  logic                                line_start,
  object_line_evaluator_m_if.master           obm,
  output logic [MAX_SLOTS-1:0]                slot_valid,
  output logic [6*MAX_SLOTS-1:0]              slot_obma,
  output logic [3*MAX_SLOTS-1:0]              slot_row,
  output logic [$clog2(NUM_OBJECTS+1)-1:0]   hit_count,
  output logic                                overflow,
  output logic                                busy,
  output logic                                done
);

  // state  | meaning
  // IDLE   | table held, waiting for line_start
  // SCAN   | issuing OBM reads and comparing the returned Y one cycle later
  // COMMIT | copy back table to outputs, pulse done

  localparam int IDX_W = $clog2(NUM_OBJECTS) + 1;
  localparam int HC_W  = $clog2(NUM_OBJECTS + 1);

  eval_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       target_q, target_d;
  logic             cmp_valid_q;
  logic [5:0]       cmp_obma_q;
  logic             done_q;
  logic             issuing;
  logic             y_hidden;
  logic             tbl_clear, tbl_commit, tbl_hit;
  obj_slot_t        hit_slot;

  assign issuing      = (state_q == SCAN) && (idx_q < IDX_W'(NUM_OBJECTS));
  assign obm.obm_addr = issuing ? {6'(idx_q), OBM_YP_OFS} : 8'd0;

`ifdef OBJECT_YHIDE_EN
  assign y_hidden = obm.obm_data >= 8'(SCREEN_VISIBLE_LINES);
`else
  assign y_hidden = 1'b0;
`endif

  assign hit_slot.obma = cmp_obma_q;
  assign hit_slot.row  = 3'(target_q - obm.obm_data);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    target_d   = target_q;
    tbl_clear  = 1'b0;
    tbl_commit = 1'b0;
    tbl_hit    = 1'b0;
    // A new line_start wins in any state: the half-built table is discarded.
    if (line_start) begin
      target_d  = yp + 8'd1;
      idx_d     = '0;
      tbl_clear = 1'b1;
      state_d   = SCAN;
    end else begin
      case (state_q)
        SCAN: begin
          if (issuing) idx_d = idx_q + IDX_W'(1);
          if (cmp_valid_q) begin
            tbl_hit = obj_y_hit(target_q, obm.obm_data) && !y_hidden;
            if (cmp_obma_q == 6'(NUM_OBJECTS - 1)) state_d = COMMIT;
          end
        end
        COMMIT: begin
          tbl_commit = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      target_q    <= '0;
      cmp_valid_q <= 1'b0;
      cmp_obma_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      target_q    <= target_d;
      cmp_valid_q <= issuing && !line_start;
      cmp_obma_q  <= 6'(idx_q);
      done_q      <= tbl_commit;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  object_slot_table_m #(
    .MAX_SLOTS (MAX_SLOTS),
    .HC_W      (HC_W)
  ) u_slot_table (
    .clk        (clk),
    .rst        (rst),
    .clear      (tbl_clear),
    .hit        (tbl_hit),
    .hit_slot   (hit_slot),
    .commit     (tbl_commit),
    .slot_valid (slot_valid),
    .slot_obma  (slot_obma),
    .slot_row   (slot_row),
    .hit_count  (hit_count),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_object_line_evaluator_m.sv
// Scoreboard bench for object_line_evaluator_m: directed scanlines against a
// behavioural OBM, expected tables queued by stimulus and checked on done.
module tb_object_line_evaluator_m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  yp = 8'd0;
  logic        line_start = 1'b0;
  logic [7:0]  slot_valid;
  logic [47:0] slot_obma;
  logic [23:0] slot_row;
  logic [6:0]  hit_count;
  logic        overflow, busy, done;

  object_line_evaluator_m_if bus ();

  object_line_evaluator_m dut (
    .clk        (clk),
    .rst        (rst),
    .yp         (yp),
    .line_start (line_start),
    .obm        (bus.master),
    .slot_valid (slot_valid),
    .slot_obma  (slot_obma),
    .slot_row   (slot_row),
    .hit_count  (hit_count),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [7:0] yp_mem [64];
  always @(posedge clk) bus.obm_data <= yp_mem[bus.obm_addr[7:2]];

  typedef struct {
    logic [7:0]  v;
    logic [47:0] o;
    logic [23:0] r;
    logic [6:0]  hc;
    logic        ovf;
    longint      cyc;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   cur_exp;
  exp_t   bld;
  int     bld_n;
  longint cyc = 0;
  longint ls_cyc;
  int     checks = 0;
  int     fails = 0;
  bit     mon_en = 0;
  bit     rst_window = 0;
  int     done_seen = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops on done, otherwise requires the last committed table to hold.
  always @(negedge clk) begin
    if (done) done_seen++;
    if (mon_en && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        cur_exp = exp_q.pop_front();
        chk("slot_valid", 64'(slot_valid), 64'(cur_exp.v));
        chk("slot_obma",  64'(slot_obma),  64'(cur_exp.o & {8{6'h3F & {6{1'b1}}}} & mask_o(cur_exp.v)));
        chk("slot_row",   64'(slot_row),   64'(cur_exp.r & mask_r(cur_exp.v)));
        chk("hit_count",  64'(hit_count),  64'(cur_exp.hc));
        chk("overflow",   64'(overflow),   64'(cur_exp.ovf));
        chk("done_latency", 64'(cyc), 64'(cur_exp.cyc));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end else if (mon_en && !rst_window) begin
      chk("hold_valid", 64'(slot_valid), 64'(cur_exp.v));
      chk("hold_obma",  64'(slot_obma),  64'(cur_exp.o & mask_o(cur_exp.v)));
      chk("hold_hc",    64'(hit_count),  64'(cur_exp.hc));
    end
  end

  function automatic logic [47:0] mask_o(input logic [7:0] v);
    logic [47:0] m = '0;
    for (int k = 0; k < 8; k++) if (v[k]) m[6*k +: 6] = 6'h3F;
    return m;
  endfunction

  function automatic logic [23:0] mask_r(input logic [7:0] v);
    logic [23:0] m = '0;
    for (int k = 0; k < 8; k++) if (v[k]) m[3*k +: 3] = 3'h7;
    return m;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) yp_mem[i] = 8'd200;
  endtask

  task automatic exp_begin();
    bld = '{v: '0, o: '0, r: '0, hc: '0, ovf: 1'b0, cyc: 0};
    bld_n = 0;
  endtask

  task automatic exp_add(input logic [5:0] obma, input logic [2:0] row);
    bld.v[bld_n]       = 1'b1;
    bld.o[6*bld_n +: 6] = obma;
    bld.r[3*bld_n +: 3] = row;
    bld_n++;
  endtask

  task automatic exp_push(input int hc, input logic ovf);
    bld.hc  = 7'(hc);
    bld.ovf = ovf;
    bld.cyc = ls_cyc + 67;
    exp_q.push_back(bld);
  endtask

  task automatic start_line(input logic [7:0] y);
    @(negedge clk);
    yp = y;
    line_start = 1'b1;
    ls_cyc = cyc;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      fails++;
      $display("FAIL timeout: got no done within 300 cycles expected done");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_line(input logic [7:0] y, input int hc, input logic ovf);
    start_line(y);
    exp_push(hc, ovf);
    wait_idle();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    clear_mem();
    cur_exp = '{v: '0, o: '0, r: '0, hc: '0, ovf: 1'b0, cyc: 0};
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(slot_valid), 64'd0);
    chk("rst_obma",  64'(slot_obma),  64'd0);
    chk("rst_row",   64'(slot_row),   64'd0);
    chk("rst_hc",    64'(hit_count),  64'd0);
    chk("rst_ovf",   64'(overflow),   64'd0);
    chk("rst_busy",  64'(busy),       64'd0);
    chk("rst_done",  64'(done),       64'd0);
    chk("rst_addr",  64'(bus.obm_addr), 64'd0);
    rst = 1'b0;
    mon_en = 1;

    // Single object, row 3.
    yp_mem[0] = 8'd128;
    exp_begin(); exp_add(6'd0, 3'd3);
    run_line(8'd130, 1, 1'b0);

    // Ten hits: first eight kept, overflow.
    clear_mem();
    for (int i = 0; i < 10; i++) yp_mem[i] = 8'd50;
    exp_begin();
    for (int i = 0; i < 8; i++) exp_add(6'(i), 3'd0);
    run_line(8'd49, 10, 1'b1);

    // Vertical boundaries of a YP=100 object.
    clear_mem();
    yp_mem[5] = 8'd100;
    exp_begin();                         run_line(8'd98,  0, 1'b0);
    exp_begin(); exp_add(6'd5, 3'd0);    run_line(8'd99,  1, 1'b0);
    exp_begin(); exp_add(6'd5, 3'd7);    run_line(8'd106, 1, 1'b0);
    exp_begin();                         run_line(8'd107, 0, 1'b0);

    // No wrap from line 255 onto line 0.
    clear_mem();
    yp_mem[3] = 8'd252;
    exp_begin();                         run_line(8'd255, 0, 1'b0);
    exp_begin(); exp_add(6'd3, 3'd3);    run_line(8'd254, 1, 1'b0);

    // Off-screen hide range.
    clear_mem();
    yp_mem[7] = 8'd245;
    exp_begin();
`ifdef OBJECT_YHIDE_EN
    run_line(8'd245, 0, 1'b0);
`else
    exp_add(6'd7, 3'd1);
    run_line(8'd245, 1, 1'b0);
`endif

    // Exactly eight hits, rows 0..7, including the last OBM index.
    clear_mem();
    yp_mem[2]  = 8'd65; yp_mem[9]  = 8'd64; yp_mem[17] = 8'd63; yp_mem[30] = 8'd62;
    yp_mem[41] = 8'd61; yp_mem[50] = 8'd60; yp_mem[58] = 8'd59; yp_mem[63] = 8'd58;
    exp_begin();
    exp_add(6'd2, 3'd0);  exp_add(6'd9, 3'd1);  exp_add(6'd17, 3'd2); exp_add(6'd30, 3'd3);
    exp_add(6'd41, 3'd4); exp_add(6'd50, 3'd5); exp_add(6'd58, 3'd6); exp_add(6'd63, 3'd7);
    run_line(8'd64, 8, 1'b0);

    // Restart 20 cycles into a scan; only the second line commits.
    clear_mem();
    yp_mem[1]  = 8'd10;
    yp_mem[40] = 8'd70;
    start_line(8'd10);
    repeat (18) @(negedge clk);
    start_line(8'd70);
    exp_begin(); exp_add(6'd40, 3'd1);
    exp_push(1, 1'b0);
    wait_idle();

    // Reset 30 cycles into a scan over a non-empty table.
    start_line(8'd10);
    repeat (29) @(negedge clk);
    rst_window = 1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_exp = '{v: '0, o: '0, r: '0, hc: '0, ovf: 1'b0, cyc: 0};
    chk("mid_rst_valid", 64'(slot_valid), 64'd0);
    chk("mid_rst_obma",  64'(slot_obma),  64'd0);
    chk("mid_rst_row",   64'(slot_row),   64'd0);
    chk("mid_rst_hc",    64'(hit_count),  64'd0);
    chk("mid_rst_busy",  64'(busy),       64'd0);
    rst_window = 0;
    done_seen = 0;
    repeat (100) @(negedge clk);
    chk("no_done_after_rst", 64'(done_seen), 64'd0);

    // Normal operation after the reset.
    exp_begin(); exp_add(6'd40, 3'd1);
    run_line(8'd70, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/object_line_evaluator_m.md
Name: object_line_evaluator_m

Overview:
- Upstream neighbour of the foreground pixel stage.
- During horizontal blank it scans Object Memory (OBM) for every object that intersects the next scanline.
- It selects up to MAX_SLOTS hits in ascending OBM index order and publishes a stable slot table: object index plus pattern row per slot.
- The foreground stage uses this table during the following visible line instead of a hard-wired object 0.

Parameters:
- NUM_OBJECTS, 64, objects scanned; OBM holds 4 bytes per object.
- MAX_SLOTS, 8, maximum objects published per line.

Ports:
- clk  in  1  pixel clock (12.5875 MHz).
- rst  in  1  reset; synchronous, active-high.
- yp  in  8  current scanline; sampled on line_start.
- line_start  in  1  single-cycle pulse at start of hblank.
- obm_addr  out  8  OBM read address {obma[5:0], 2'd1}, i.e. the YP byte.
- obm_data  in  8  OBM read data; valid exactly 1 cycle after obm_addr.
- slot_valid  out  MAX_SLOTS  slot occupied.
- slot_obma  out  6*MAX_SLOTS  object index; slot k at bits [6k+:6].
- slot_row  out  3*MAX_SLOTS  pattern row (target_y - object YP); slot k at [3k+:3].
- hit_count  out  $clog2(NUM_OBJECTS+1)  total hits found, including dropped ones.
- overflow  out  1  more than MAX_SLOTS hits on the committed line.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; the new table is visible in the same cycle.

Behaviour:
- Reset values:
  - slot_valid = 0, slot_obma = 0, slot_row = 0, hit_count = 0, overflow = 0.
  - busy = 0, done = 0, obm_addr = 0, state IDLE.
  - The back table is also cleared.
- States: IDLE -> SCAN -> COMMIT -> IDLE.
- IDLE:
  - On line_start, latch target_y = yp + 1, mod 256 (yp = 255 -> 0).
  - Clear the back table and hit counter, set idx = 0, go to SCAN.
- SCAN:
  - Each cycle drive obm_addr = {idx, 2'd1} and increment idx.
  - Compares are pipelined: obm_data for index i is evaluated in the cycle after its issue.
  - Hit test uses 9-bit arithmetic, no vertical wrap: hit iff target_y >= YP and target_y < YP + 8. An object at YP = 252 hits lines 252..255 only.
  - On a hit: if the back slot count < MAX_SLOTS, write {obma, row} into the next free back slot and set its valid bit. Otherwise set back_overflow and drop the object.
  - hit_count always increments on a hit.
  - After the compare of index NUM_OBJECTS-1, go to COMMIT.
- COMMIT:
  - Copy the back table, hit count and overflow into the output registers atomically.
  - Pulse done, go to IDLE.
- Latency: done is asserted exactly NUM_OBJECTS+3 cycles (67) after the cycle line_start is sampled. busy is high from the cycle after line_start until the cycle before done.
- Outputs change only at commit and are otherwise held stable, including across the whole visible line.
- line_start during SCAN or COMMIT: abort, discard the back table, restart the scan with the newly sampled yp. The output table is unchanged until the restarted scan commits.
- rst mid-scan: immediately IDLE; all outputs return to reset values in the next cycle.
- Zero hits: commit sets slot_valid = 0, hit_count = 0, overflow = 0.
- Exactly MAX_SLOTS hits: all slots valid, overflow = 0.

Optional Feature:
- Macro: OBJECT_YHIDE_EN.
- Defined: an object with YP >= 240 never hits, and is not counted in hit_count or overflow. This gives software an off-screen "hide" value.
- Undefined: YP is compared purely arithmetically, so YP = 240..255 can hit lines 240..255.

Decomposition:
- Shared package gpu_pkg holds:
  - OBM byte offsets: OBM_XP_OFS = 0, OBM_YP_OFS = 1, OBM_ATTR_OFS = 2, OBM_COLOR_OFS = 3.
  - SCREEN_VISIBLE_LINES = 240, OBJECT_SIZE = 8.
  - A typedef obj_slot_t {logic [5:0] obma; logic [2:0] row;}.
  - The state enum eval_state_t {IDLE, SCAN, COMMIT}.
- Natural sub-module: object_slot_table_m. It is the back/active slot register bank with fill pointer, overflow flag and commit copy, instantiated once.

Test Plan:
- Object 0 YP = 128 only, others YP = 0xFF with OBJECT_YHIDE_EN. line_start with yp = 130 -> done after 67 cycles; slot0 = {obma 0, row 3}; slot_valid = 8'h01; hit_count = 1; overflow = 0.
- Objects 0..9 all YP = 50, yp = 49 -> slots 0..7 = obma 0..7 with row 0; slot_valid = 8'hFF; hit_count = 10; overflow = 1.
- Boundaries, object 5 YP = 100:
  - yp = 98 (target 99) -> no hit.
  - yp = 99 -> row 0.
  - yp = 106 -> row 7.
  - yp = 107 -> no hit.
- Wrap: object 3 YP = 252, yp = 255 (target 0) -> no hit. Macro undefined, yp = 254 -> hit with row 3.
- line_start re-asserted 20 cycles into a scan with new yp -> outputs unchanged until a single done at 67 cycles after the second pulse; the table reflects the second yp.
- rst asserted at cycle 30 of a scan following a committed non-empty table -> next cycle all outputs 0, busy = 0, and no done pulse.
